morse_symbol_module: RTL

Parameterised Morse letter generator: while its start request is held high it drives a single output pin with one letter's dot/dash pattern, then pulses a one-cycle done flag. It sits directly downstream of the SOS sequencer; two instances (S and O) receive `S_Start_Sig` / `O_Start_Sig` and return `S_Done_Sig` / `O_Done_Sig`. The pin outputs of the two instances are ORed to the LED/buzzer pin.

---
 rtl/morse_symbol_module.sv | 121 ++++++++++++
 1 files changed

// File: rtl/morse_symbol_module.sv
// Morse letter generator: while Start_Sig is held, plays CODE[LEN-1:0] (MSB first, 1=dash)
// on Pin_Out, then a 3-unit tail gap and a single-cycle Done_Sig pulse.
module morse_symbol_module #(
    parameter int unsigned T_UNIT = 2_000_000,
    parameter int unsigned LEN    = 3,
    parameter logic [5:0]  CODE   = 6'b000000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Start_Sig,
    output logic Pin_Out,
    output logic Done_Sig
);

    typedef enum logic [2:0] {
        StIdle,
        StOn,
        StGap,
        StTail,
        StDone,
        StWaitLow
    } state_e;

    localparam logic [23:0] TickLast  = 24'(T_UNIT - 1);
    localparam logic [2:0]  IdxFirst  = (LEN > 0) ? 3'(LEN - 1) : 3'd0;
    localparam logic [7:0]  CodePad   = {2'b00, CODE};
    localparam bit          HasElems  = (LEN > 0);

    state_e      r_state;
    logic [23:0] r_tick;
    logic [1:0]  r_units;
    logic [2:0]  r_idx;
    logic        r_pin;
    logic        r_done;

    logic        w_unit_end;
    logic [1:0]  w_units_next;
    logic [1:0]  w_elem_units;

    assign w_unit_end   = (r_tick == TickLast);
    assign w_units_next = r_units + 2'd1;
    assign w_elem_units = CodePad[r_idx] ? 2'd3 : 2'd1;

    assign Pin_Out  = r_pin;
    assign Done_Sig = r_done;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StIdle;
            r_tick  <= '0;
            r_units <= '0;
            r_idx   <= '0;
            r_pin   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (Start_Sig) begin
                        r_tick  <= '0;
                        r_units <= '0;
                        r_idx   <= IdxFirst;
                        if (HasElems) begin
                            r_pin   <= 1'b1;
                            r_state <= StOn;
                        end else begin
                            r_state <= StTail;
                        end
                    end
                end
                StOn, StGap, StTail: begin
                    // Dropping the request aborts the letter silently.
                    if (!Start_Sig) begin
                        r_pin   <= 1'b0;
                        r_tick  <= '0;
                        r_units <= '0;
                        r_idx   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_tick <= w_unit_end ? 24'd0 : r_tick + 24'd1;
                        if (w_unit_end) begin
                            if (r_state == StOn) begin
                                if (w_units_next == w_elem_units) begin
                                    r_units <= '0;
                                    r_pin   <= 1'b0;
                                    r_state <= (r_idx == 3'd0) ? StTail : StGap;
                                end else begin
                                    r_units <= w_units_next;
                                end
                            end else if (r_state == StGap) begin
                                r_units <= '0;
                                r_idx   <= r_idx - 3'd1;
                                r_pin   <= 1'b1;
                                r_state <= StOn;
                            end else begin
                                if (w_units_next == 2'd3) begin
                                    r_units <= '0;
                                    r_done  <= 1'b1;
                                    r_state <= StDone;
                                end else begin
                                    r_units <= w_units_next;
                                end
                            end
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StWaitLow;
                end
                StWaitLow: begin
                    // Sequencer still holds start in the cycle it sees done; wait for release.
                    if (!Start_Sig) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
